// File: rtl/crc4_encoder.sv
// crc4_encoder: bit-serial CRC-4 generator (G(x) = x^4 + x + 1).
// Accepts a 4-bit nibble, shifts it MSB first through an LFSR over four
// clocks, then presents the codeword {data, crc} until downstream takes it.

module crc4_encoder #(
    parameter logic [3:0] POLY  = 4'b0011,
    parameter int         NBITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] InData,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] OutputData,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(NBITS - 1);

    state_t     state;
    logic [3:0] data_q;
    logic [3:0] crc;
    logic [1:0] cnt;
    logic       data_bit;
    logic       fb;
    logic [3:0] next_crc;

    // One LFSR step: select the current data bit (MSB first) and fold it into the remainder
    always_comb begin
        data_bit = data_q[2'd3 - cnt];
        fb       = data_bit ^ crc[3];
        next_crc = {crc[2:0], 1'b0} ^ (fb ? POLY : 4'b0000);
    end

    // Handshake FSM with the LFSR state and registered codeword outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_q     <= 4'b0000;
            crc        <= 4'b0000;
            cnt        <= 2'd0;
            OutputData <= 8'h00;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= InData;
                        crc    <= 4'b0000;
                        cnt    <= 2'd0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    crc <= next_crc;
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST_CNT) begin
                        OutputData <= {data_q, next_crc};
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Handshake/status flags follow directly from the state register
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
